// File: rtl/msg_schedule_expander.sv
// SHA-256 message-schedule producer: loads W0..W15 over a valid/ready input and
// streams W0..W(ROUNDS-1) to the round engine, expanding words in place in a 16-entry ring.
module msg_schedule_expander #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic [0:0]       dbg_state
);

  // Handshakes: a word moves on a port exactly in a cycle where valid and ready
  // are both high at the rising edge; out_valid, once raised, holds with stable
  // out_data/out_index until its handshake, and in_valid/out_ready are ignored
  // outside LOAD/STREAM respectively.
  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_t;
  logic             r_done;
  logic [31:0]      r_buf [16];

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_ext;
  logic             w_last;
  logic [3:0]       w_t_lo;
  logic [3:0]       w_i1;
  logic [3:0]       w_i9;
  logic [3:0]       w_i14;
  logic [31:0]      w_sched;
  logic [31:0]      w_word;

  function automatic logic [31:0] f_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  assign w_t_lo = r_t[3:0];
  assign w_i1   = w_t_lo + 4'd1;
  assign w_i9   = w_t_lo + 4'd9;
  assign w_i14  = w_t_lo + 4'd14;

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_STREAM);
  assign busy      = (r_state == ST_STREAM);
  assign done      = r_done;
  assign dbg_state = r_state;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_ext    = (r_t >= IDX_W'(16));
  assign w_last   = (r_t == IDX_W'(ROUNDS - 1));

  // Ring slot t%16 still holds W(t-16); neighbours give W(t-15), W(t-7), W(t-2).
  assign w_sched = f_sigma1(r_buf[w_i14]) + r_buf[w_i9] + f_sigma0(r_buf[w_i1]) + r_buf[w_t_lo];
  assign w_word  = w_ext ? w_sched : r_buf[w_t_lo];

  assign out_data  = busy ? w_word : 32'd0;
  assign out_index = busy ? r_t : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_t     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_in_hs) begin
            if (r_t == IDX_W'(15)) begin
              r_t     <= '0;
              r_state <= ST_STREAM;
            end else begin
              r_t <= r_t + IDX_W'(1);
            end
          end
        end
        default: begin
          if (w_out_hs) begin
            if (w_last) begin
              r_t     <= '0;
              r_state <= ST_LOAD;
              r_done  <= 1'b1;
            end else begin
              r_t <= r_t + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Storage has no reset; its contents only matter after a complete LOAD.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_in_hs) begin
        r_buf[w_t_lo] <= in_data;
      end else if (w_out_hs && w_ext) begin
        r_buf[w_t_lo] <= w_sched;
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule_expander.sv
// Directed bench for msg_schedule_expander: SHA-256 "abc" and one-hot blocks,
// stalls, input gaps, mid-stream reset and back-to-back blocks.
module tb_msg_schedule_expander;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_index;
  logic             busy;
  logic             done;
  logic [0:0]       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0]      blk_a [16];
  logic [31:0]      blk_b [16];
  logic [31:0]      got_w [64];
  logic [31:0]      exp_q [$];
  logic [IDX_W-1:0] idx_q [$];

  msg_schedule_expander #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model ----
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void push_block(input int sel);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = (sel == 0) ? blk_a[i] : blk_b[i];
    for (int i = 16; i < 64; i++) w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
    for (int i = 0; i < ROUNDS; i++) begin
      exp_q.push_back(w[i]);
      idx_q.push_back(IDX_W'(i));
    end
  endfunction

  // ---- driver tasks ----
  task automatic load_block(input int sel, input int gap_pct);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < 16 && cyc < 2000) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b1;
        in_data  = (sel == 0) ? blk_a[i] : blk_b[i];
      end
      #1;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (i != 16) begin
      tests_failed++;
      $display("FAIL load_timeout: accepted %0d words, required 16", i);
    end
  endtask

  // Accepts n words, checking each against the scoreboard; returns done pulses seen.
  task automatic drain(input int n, input int stall_pct, input bit expect_done, output int dones);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0]      hold_d = '0;
    logic [IDX_W-1:0] hold_i = '0;
    logic [31:0]      e_d;
    logic [IDX_W-1:0] e_i;
    dones = 0;
    while (got < n && cyc < 4000) begin
      out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      #1;
      if (done) dones++;
      if (stalled) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_index !== hold_i) begin
          tests_failed++;
          $display("FAIL stall_stable: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                   out_valid, out_data, out_index, hold_d, hold_i);
        end
      end
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          e_d = exp_q.pop_front();
          e_i = idx_q.pop_front();
          got_w[e_i] = out_data;
          tests_run++;
          if (out_data !== e_d || out_index !== e_i) begin
            tests_failed++;
            $display("FAIL word_%0d: data=%h idx=%0d, required data=%h idx=%0d",
                     got, out_data, out_index, e_d, e_i);
          end
          got++;
        end else begin
          stalled = 1;
          hold_d  = out_data;
          hold_i  = out_index;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (got != n) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got, n);
    end
    if (expect_done) begin
      tests_run++;
      if (done !== 1'b1) begin
        tests_failed++;
        $display("FAIL done_pulse: done=%b, required 1", done);
      end
    end
    if (done === 1'b1) dones++;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_index !== '0 || out_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b val=%b busy=%b done=%b idx=%0d data=%h, required 1 0 0 0 0 0",
               in_ready, out_valid, busy, done, out_index, out_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    int d;
    exp_q.delete(); idx_q.delete();
    push_block(0);
    load_block(0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_index !== '0 || out_data !== 32'h61626380) begin
      tests_failed++;
      $display("FAIL abc_latency: val=%b busy=%b rdy=%b idx=%0d data=%h, required 1 1 0 0 61626380",
               out_valid, busy, in_ready, out_index, out_data);
    end
    drain(64, 0, 1'b1, d);
    tests_run++;
    if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
      tests_failed++;
      $display("FAIL abc_w16_w17: %h %h, required 61626380 000f0000", got_w[16], got_w[17]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (d != 1 || done !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abc_single_done: pulses=%0d done_now=%b rdy=%b, required 1 0 1", d, done, in_ready);
    end
  endtask

  task automatic test_sigma0();
    int d;
    for (int i = 0; i < 16; i++) blk_b[i] = 32'd0;
    blk_b[1] = 32'h00000001;
    exp_q.delete(); idx_q.delete();
    push_block(1);
    load_block(1, 0);
    drain(64, 0, 1'b1, d);
    // W17 also picks up W1 through its t-16 term.
    tests_run++;
    if (got_w[16] !== 32'h02004000 || got_w[17] !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL sigma0_w16_w17: %h %h, required 02004000 00000001", got_w[16], got_w[17]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int d;
    exp_q.delete(); idx_q.delete();
    push_block(0);
    load_block(0, 0);
    drain(64, 50, 1'b1, d);
    tests_run++;
    if (d != 1) begin
      tests_failed++;
      $display("FAIL stall_done_count: %0d pulses, required 1", d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_in_gaps();
    int d;
    exp_q.delete(); idx_q.delete();
    push_block(0);
    load_block(0, 50);
    drain(64, 0, 1'b1, d);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int d;
    exp_q.delete(); idx_q.delete();
    push_block(0);
    load_block(0, 0);
    drain(30, 0, 1'b0, d);
    tests_run++;
    if (out_index !== IDX_W'(30) || d != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: idx=%0d dones=%0d, required 30 0", out_index, d);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: val=%b rdy=%b done=%b busy=%b, required 0 1 0 0",
               out_valid, in_ready, done, busy);
    end
    d = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) d++;
    end
    tests_run++;
    if (d != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_no_done: %0d pulses, required 0", d);
    end
    exp_q.delete(); idx_q.delete();
    push_block(0);
    load_block(0, 0);
    drain(64, 0, 1'b1, d);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int d;
    for (int i = 0; i < 16; i++) blk_b[i] = (32'h01010101 * i) ^ 32'h9E3779B9;
    exp_q.delete(); idx_q.delete();
    push_block(0);
    push_block(1);
    fork
      begin
        load_block(0, 0);
        in_valid = 1'b1;
        load_block(1, 0);
      end
      drain(128, 0, 1'b1, d);
    join
    tests_run++;
    if (d != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: %0d pulses, required 2", d);
    end
    @(posedge clk); #1;
  endtask

  // ---- main sequence and report ----
  initial begin
    blk_a[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk_a[i] = 32'd0;
    blk_a[15] = 32'h00000018;
    for (int i = 0; i < 64; i++) got_w[i] = 32'd0;
    test_reset();
    test_abc();
    test_sigma0();
    test_stall();
    test_in_gaps();
    test_mid_reset();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: %0d words left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
